// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the parametrised register file.
//   state_t     : scrub sequencer states (IDLE, CLEAR)
//   DEF_*       : default WIDTH / DEPTH / NREAD for regfile_param
//   addr_w()    : address width for a given register count
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_word.sv
// regfile_word: one WIDTH-bit storage word of the register file.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the word
//   we      : write enable
//   d       : write data
//   q       : stored value
module regfile_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] word_r;

    // Storage register: load on write enable, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_r <= {WIDTH{1'b0}};
        end else if (we) begin
            word_r <= d;
        end else begin
            word_r <= word_r;
        end
    end

    assign q = word_r;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with NREAD combinational read
// ports, one write port, a hardwired zero register at index DEPTH-1 and a
// clear sequencer that scrubs one word per cycle.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   RegWrite       : write enable
//   WriteRegister  : write address (AW bits)
//   WriteData      : write data (WIDTH bits)
//   ReadRegister   : NREAD packed read addresses, port p at [p*AW +: AW]
//   ReadData       : NREAD packed read data, port p at [p*WIDTH +: WIDTH]
//   clear_req      : pulse to start a scrub (ignored while busy)
//   busy           : high while the scrub runs
//   write_dropped  : one-cycle pulse after a write arrived during a scrub
// Build option: define REGFILE_BYPASS_EN to forward an IDLE write to any
// read port addressing the same register in the same cycle.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NREAD = DEF_NREAD
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          RegWrite,
    input  logic [addr_w(DEPTH)-1:0]      WriteRegister,
    input  logic [WIDTH-1:0]              WriteData,
    input  logic [NREAD*addr_w(DEPTH)-1:0] ReadRegister,
    output logic [NREAD*WIDTH-1:0]        ReadData,
    input  logic                          clear_req,
    output logic                          busy,
    output logic                          write_dropped
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [AW-1:0]    ptr_r;
    logic [AW-1:0]    ptr_nxt_s;
    logic             write_dropped_r;
    logic             write_dropped_nxt_s;
    logic             idle_write_s;
    logic [DEPTH-2:0] word_we_s;
    logic [WIDTH-1:0] word_d_s;
    logic [WIDTH-1:0] word_q_s [DEPTH];

    // A normal write only happens in IDLE and never targets the zero register.
    always_comb begin
        idle_write_s = (state_r == IDLE) && RegWrite && (WriteRegister != ZERO_IDX);
    end

    // Scrub sequencer next state: ptr walks 0..DEPTH-2 and stops there.
    always_comb begin
        state_nxt_s         = state_r;
        ptr_nxt_s           = ptr_r;
        write_dropped_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_nxt_s = CLEAR;
                    ptr_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                write_dropped_nxt_s = RegWrite;
                if (ptr_r == LAST_IDX) begin
                    state_nxt_s = IDLE;
                end else begin
                    ptr_nxt_s = ptr_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state, scrub pointer and dropped-write flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            ptr_r           <= {AW{1'b0}};
            write_dropped_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            ptr_r           <= ptr_nxt_s;
            write_dropped_r <= write_dropped_nxt_s;
        end
    end

    // Write decoder: the scrub and the normal write share one enable/data
    // path per word; in CLEAR only the word at ptr is written, with zero.
    always_comb begin
        word_we_s = {(DEPTH-1){1'b0}};
        word_d_s  = {WIDTH{1'b0}};
        if (state_r == CLEAR) begin
            word_d_s = {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH - 1; i++) begin
                word_we_s[i] = (ptr_r == AW'(i));
            end
        end else begin
            word_d_s = WriteData;
            for (int i = 0; i < DEPTH - 1; i++) begin
                word_we_s[i] = idle_write_s && (WriteRegister == AW'(i));
            end
        end
    end

    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_word
        regfile_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (word_we_s[g]),
            .d       (word_d_s),
            .q       (word_q_s[g])
        );
    end

    // The zero register has no storage.
    assign word_q_s[DEPTH-1] = {WIDTH{1'b0}};

    // Read multiplexers, one per port, with optional same-cycle forwarding.
    always_comb begin
        ReadData = {(NREAD*WIDTH){1'b0}};
        for (int p = 0; p < NREAD; p++) begin
`ifdef REGFILE_BYPASS_EN
            if (idle_write_s && (ReadRegister[p*AW +: AW] == WriteRegister)) begin
                ReadData[p*WIDTH +: WIDTH] = WriteData;
            end else begin
                ReadData[p*WIDTH +: WIDTH] = word_q_s[ReadRegister[p*AW +: AW]];
            end
`else
            ReadData[p*WIDTH +: WIDTH] = word_q_s[ReadRegister[p*AW +: AW]];
`endif
        end
    end

    assign busy          = (state_r == CLEAR);
    assign write_dropped = write_dropped_r;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed, scoreboard-based bench for regfile_param.
// Instance A runs the default configuration (64x32, two read ports);
// instance B runs WIDTH=32, DEPTH=16, NREAD=3.
module tb_regfile_param;

    localparam logic [63:0] PAT = 64'h0000010204080001;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_we, a_clr, a_busy, a_drop;
    logic [4:0]  a_wa;
    logic [63:0] a_wd;
    logic [9:0]  a_ra;
    logic [127:0] a_rd;

    logic        b_we, b_clr, b_busy, b_drop;
    logic [3:0]  b_wa;
    logic [31:0] b_wd;
    logic [11:0] b_ra;
    logic [95:0] b_rd;

    logic [63:0] a_mem [32];
    logic [63:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cnt;

    regfile_param u_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWrite      (a_we),
        .WriteRegister (a_wa),
        .WriteData     (a_wd),
        .ReadRegister  (a_ra),
        .ReadData      (a_rd),
        .clear_req     (a_clr),
        .busy          (a_busy),
        .write_dropped (a_drop)
    );

    regfile_param #(.WIDTH(32), .DEPTH(16), .NREAD(3)) u_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWrite      (b_we),
        .WriteRegister (b_wa),
        .WriteData     (b_wd),
        .ReadRegister  (b_ra),
        .ReadData      (b_rd),
        .clear_req     (b_clr),
        .busy          (b_busy),
        .write_dropped (b_drop)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input logic [63:0] v);
        sb_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [63:0] data);
        a_we = 1'b1; a_wa = addr; a_wd = data;
        @(posedge clk); #1;
        a_we = 1'b0;
        if (addr != 5'd31) a_mem[addr] = data;
    endtask

    task automatic a_read(input int p, input logic [4:0] addr, input string tag);
        a_ra[p*5 +: 5] = addr;
        #1;
        expect_v(a_mem[addr]);
        check(tag, a_rd[p*64 +: 64]);
    endtask

    task automatic a_clear_model();
        for (int i = 0; i < 32; i++) a_mem[i] = 64'd0;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data);
        b_we = 1'b1; b_wa = addr; b_wd = data;
        @(posedge clk); #1;
        b_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        a_we = 1'b0; a_clr = 1'b0; a_wa = 5'd0; a_wd = 64'd0; a_ra = 10'd0;
        b_we = 1'b0; b_clr = 1'b0; b_wa = 4'd0; b_wd = 32'd0; b_ra = 12'd0;
        a_clear_model();
        #12;
        // reset state
        expect_v(64'd0); check("rst_busy", {63'd0, a_busy});
        expect_v(64'd0); check("rst_drop", {63'd0, a_drop});
        a_read(0, 5'd0, "rst_rd0");
        a_read(1, 5'd17, "rst_rd1");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // zero register
        a_write(5'd31, 64'hA0);
        expect_v(64'd0); check("zero_drop", {63'd0, a_drop});
        a_read(0, 5'd31, "zero_p0");
        a_read(1, 5'd31, "zero_p1");

        // pattern fill and cross-read
        for (int i = 0; i < 31; i++) a_write(5'(i), 64'(i) * PAT);
        for (int i = 0; i < 31; i++) begin
            a_read(0, 5'(i), "fill_p0");
            a_read(1, 5'(30 - i), "fill_p1");
            @(posedge clk); #1;
        end

        // scrub with a dropped write and an ignored clear_req
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            expect_v(64'd1); check("scrub_busy", {63'd0, a_busy});
            a_ra[4:0] = 5'(k - 1);
            a_ra[9:5] = (k == 4) ? 5'd5 : ((k >= 2) ? 5'(k - 2) : 5'd31);
            if (k == 3) begin a_we = 1'b1; a_wa = 5'd5; a_wd = 64'h55; end
            if (k == 10) a_clr = 1'b1;
            #1;
            expect_v(a_mem[k-1]); check("scrub_old", a_rd[63:0]);
            expect_v(a_mem[a_ra[9:5]]); check("scrub_done", a_rd[127:64]);
            if (k == 4) begin expect_v(64'd1); check("drop_pulse", {63'd0, a_drop}); end
            if (k == 5) begin expect_v(64'd0); check("drop_end", {63'd0, a_drop}); end
            @(posedge clk); #1;
            a_we = 1'b0; a_clr = 1'b0;
            a_mem[k-1] = 64'd0;
        end
        expect_v(64'd0); check("scrub_end_busy", {63'd0, a_busy});
        for (int i = 0; i < 32; i++) a_read(i % 2, 5'(i), "scrub_all0");

        // async reset mid-scrub
        @(posedge clk); #1;
        a_write(5'd0, 64'hF00); a_write(5'd15, 64'hF15); a_write(5'd30, 64'hF30);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        expect_v(64'd1); check("mid_busy", {63'd0, a_busy});
        #2;
        reset_n = 1'b0;
        a_clear_model();
        #1;
        expect_v(64'd0); check("arst_busy", {63'd0, a_busy});
        a_read(0, 5'd15, "arst_w15");
        a_read(1, 5'd30, "arst_w30");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        a_write(5'd0, 64'hC0); a_write(5'd1, 64'hC1);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        @(posedge clk); #1;
        a_mem[0] = 64'd0;
        a_read(0, 5'd0, "restart_w0");
        a_read(1, 5'd1, "restart_w1");
        cnt = 1;
        while (a_busy && cnt < 100) begin @(posedge clk); #1; cnt++; end
        expect_v(64'd31); check("restart_len", 64'(cnt));
        a_clear_model();
        a_read(1, 5'd1, "restart_end_w1");

        // same-cycle write/read
        a_write(5'd7, 64'h1234);
        a_we = 1'b1; a_wa = 5'd7; a_wd = 64'hDEAD; a_ra[4:0] = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_v(64'hDEAD);
`else
        expect_v(64'h1234);
`endif
        check("bypass_same", a_rd[63:0]);
        @(posedge clk); #1;
        a_we = 1'b0; a_mem[7] = 64'hDEAD;
        a_read(0, 5'd7, "bypass_after");
        a_we = 1'b1; a_wa = 5'd31; a_wd = 64'hBEEF; a_ra[9:5] = 5'd31;
        #1;
        expect_v(64'd0); check("bypass_zero", a_rd[127:64]);
        @(posedge clk); #1;
        a_we = 1'b0;
        expect_v(64'd0); check("zero_drop2", {63'd0, a_drop});

        // instance B: WIDTH=32, DEPTH=16, NREAD=3
        b_write(4'd2, 32'hAAAA0002); b_write(4'd9, 32'h99990009);
        b_write(4'd14, 32'hEEEE000E); b_write(4'd15, 32'hFFFFFFFF);
        b_ra = {4'd14, 4'd9, 4'd2};
        #1;
        expect_v(64'hAAAA0002); check("b_p0", {32'd0, b_rd[31:0]});
        expect_v(64'h99990009); check("b_p1", {32'd0, b_rd[63:32]});
        expect_v(64'hEEEE000E); check("b_p2", {32'd0, b_rd[95:64]});
        b_ra = {4'd2, 4'd15, 4'd15};
        #1;
        expect_v(64'd0); check("b_zero_p0", {32'd0, b_rd[31:0]});
        expect_v(64'd0); check("b_zero_p1", {32'd0, b_rd[63:32]});
        expect_v(64'hAAAA0002); check("b_same_p2", {32'd0, b_rd[95:64]});
        @(posedge clk); #1;
        b_we = 1'b1; b_wa = 4'd9; b_wd = 32'h0000DEAD; b_ra = {4'd9, 4'd0, 4'd0};
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_v(64'h0000DEAD);
`else
        expect_v(64'h99990009);
`endif
        check("b_bypass", {32'd0, b_rd[95:64]});
        @(posedge clk); #1;
        b_we = 1'b0;
        expect_v(64'h0000DEAD); check("b_after", {32'd0, b_rd[95:64]});
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        cnt = 0;
        while (b_busy && cnt < 100) begin @(posedge clk); #1; cnt++; end
        expect_v(64'd15); check("b_scrub_len", 64'(cnt));
        b_ra = {4'd14, 4'd9, 4'd2};
        #1;
        expect_v(64'd0); check("b_scrub_w14", {32'd0, b_rd[95:64]});
        expect_v(64'd0); check("b_scrub_w2", {32'd0, b_rd[31:0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
